// File: rtl/trigger_scaler_ctrl.sv
// Gated multi-channel trigger scaler. A prescaled period timer gates live counters,
// and a req/ack port reads the double-buffered count bank.
module trigger_scaler_ctrl #(
    parameter int NCH = 8,
    parameter int CW  = 16
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           enable_i,
    input  logic [7:0]     prescale_i,
    input  logic [15:0]    period_i,
    input  logic [NCH-1:0] scal_i,
    output logic           slow_ce_o,
    output logic           update_o,
    input  logic           rd_req_i,
    input  logic [2:0]     rd_addr_i,
    output logic           rd_ack_o,
    output logic [CW-1:0]  rd_data_o,
    output logic [NCH-1:0] ovf_o
);

    typedef enum logic [1:0] {IDLE, COUNT, LATCH} state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t         state;
    state_t         state_nxt;
    logic [7:0]     presc_cnt;
    logic [15:0]    tick_cnt;
    logic [15:0]    tick_last;
    logic           period_done;
    logic [CW-1:0]  live_cnt [NCH];
    logic [NCH-1:0] live_ovf;
    logic [CW-1:0]  hold_cnt [NCH];
    logic [CW-1:0]  rd_sel;
    logic           rd_take;

    // Comparisons use >= so a live shrink of prescale_i/period_i wraps at once.
    assign tick_last   = (period_i == 16'd0) ? 16'd0 : period_i - 16'd1;
    assign slow_ce_o   = (state == COUNT) && (presc_cnt >= prescale_i);
    assign period_done = slow_ce_o && (tick_cnt >= tick_last);
    assign rd_take     = rd_req_i && !rd_ack_o;

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable_i) state_nxt = COUNT;
            COUNT: begin
                if (!enable_i)        state_nxt = IDLE;
                else if (period_done) state_nxt = LATCH;
            end
            LATCH:   state_nxt = enable_i ? COUNT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            presc_cnt <= '0;
            tick_cnt  <= '0;
            update_o  <= 1'b0;
        end else begin
            state    <= state_nxt;
            update_o <= (state == LATCH);
            if (state != COUNT || slow_ce_o) presc_cnt <= '0;
            else                             presc_cnt <= presc_cnt + 8'd1;
            if (state != COUNT || period_done) tick_cnt <= '0;
            else if (slow_ce_o)                tick_cnt <= tick_cnt + 16'd1;
        end
    end

    // A pulse during LATCH seeds the new period instead of being dropped.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NCH; i++) live_cnt[i] <= '0;
            live_ovf <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (state == IDLE) begin
                    live_cnt[i] <= '0;
                    live_ovf[i] <= 1'b0;
                end else if (state == LATCH) begin
                    live_cnt[i] <= CW'(scal_i[i]);
                    live_ovf[i] <= 1'b0;
                end else if (scal_i[i]) begin
                    if (live_cnt[i] != CNT_MAX)          live_cnt[i] <= live_cnt[i] + CNT_ONE;
                    if (live_cnt[i] >= CNT_MAX - CNT_ONE) live_ovf[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(rd_addr_i) == i) rd_sel = hold_cnt[i];
        end
    end

    // NOTE: the holding bank is reset explicitly because a read right after reset must return 0.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NCH; i++) hold_cnt[i] <= '0;
            ovf_o     <= '0;
            rd_ack_o  <= 1'b0;
            rd_data_o <= '0;
        end else begin
            if (state == LATCH) begin
                hold_cnt <= live_cnt;
                ovf_o    <= live_ovf;
            end
            rd_ack_o <= rd_take;
            if (rd_take) rd_data_o <= rd_sel;
        end
    end

endmodule

// File: tb/tb_trigger_scaler_ctrl.sv
// Scoreboard bench for trigger_scaler_ctrl: a period-level reference model predicts
// latched banks, update timing and read data; a monitor compares DUT handshakes.
module tb_trigger_scaler_ctrl;

    localparam int     NCH  = 8;
    localparam int     CW   = 16;
    localparam longint MAXV = (longint'(1) << CW) - 1;

    logic           clk      = 1'b0;
    logic           rst_n    = 1'b0;
    logic           enable   = 1'b0;
    logic [7:0]     prescale = 8'd3;
    logic [15:0]    period   = 16'd4;
    logic [NCH-1:0] scal     = '0;
    logic           rd_req   = 1'b0;
    logic [2:0]     rd_addr  = 3'd0;
    logic           slow_ce;
    logic           update;
    logic           rd_ack;
    logic [CW-1:0]  rd_data;
    logic [NCH-1:0] ovf;

    trigger_scaler_ctrl #(.NCH(NCH), .CW(CW)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .enable_i   (enable),
        .prescale_i (prescale),
        .period_i   (period),
        .scal_i     (scal),
        .slow_ce_o  (slow_ce),
        .update_o   (update),
        .rd_req_i   (rd_req),
        .rd_addr_i  (rd_addr),
        .rd_ack_o   (rd_ack),
        .rd_data_o  (rd_data),
        .ovf_o      (ovf)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef enum {M_IDLE, M_COUNT, M_LATCH} mphase_t;
    typedef struct {
        int     cyc;
        longint data;
    } exp_t;

    exp_t           upd_q[$];
    exp_t           rd_q[$];
    mphase_t        m_phase = M_IDLE;
    longint         m_elapsed = 0;
    longint         m_live[NCH];
    longint         m_hold[NCH];
    logic [NCH-1:0] m_ovf = '0;
    bit             m_ack = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint period_len();
        longint p;
        p = (period == 16'd0) ? 1 : longint'(period);
        return (longint'(prescale) + 1) * p;
    endfunction

    // Reference model: a period is period_len() gated cycles followed by one latch cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                m_phase   = M_IDLE;
                m_elapsed = 0;
                m_ack     = 1'b0;
                m_ovf     = '0;
                for (int i = 0; i < NCH; i++) begin
                    m_live[i] = 0;
                    m_hold[i] = 0;
                end
                upd_q.delete();
                rd_q.delete();
            end else begin
                if (rd_req && !m_ack) begin
                    e.cyc  = cyc;
                    e.data = (int'(rd_addr) < NCH) ? m_hold[rd_addr] : 0;
                    rd_q.push_back(e);
                    m_ack = 1'b1;
                end else begin
                    m_ack = 1'b0;
                end
                case (m_phase)
                    M_IDLE: if (enable) begin
                        m_phase   = M_COUNT;
                        m_elapsed = 0;
                        for (int i = 0; i < NCH; i++) m_live[i] = 0;
                    end
                    M_COUNT: begin
                        if (!enable) m_phase = M_IDLE;
                        else begin
                            for (int i = 0; i < NCH; i++) m_live[i] += longint'(scal[i]);
                            m_elapsed++;
                            if (m_elapsed == period_len()) m_phase = M_LATCH;
                        end
                    end
                    M_LATCH: begin
                        for (int i = 0; i < NCH; i++) begin
                            m_hold[i] = (m_live[i] > MAXV) ? MAXV : m_live[i];
                            m_ovf[i]  = (m_live[i] >= MAXV);
                            m_live[i] = longint'(scal[i]);
                        end
                        e.cyc  = cyc;
                        e.data = longint'(m_ovf);
                        upd_q.push_back(e);
                        m_phase   = enable ? M_COUNT : M_IDLE;
                        m_elapsed = 0;
                    end
                    default: m_phase = M_IDLE;
                endcase
            end
        end
    end

    // Monitor: compares strobes and pops expectations whenever the DUT presents a response.
    initial begin
        exp_t   e;
        longint p1;
        longint exp_ce;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                p1     = longint'(prescale) + 1;
                exp_ce = (m_phase == M_COUNT && (m_elapsed % p1) == p1 - 1) ? 1 : 0;
                check("slow_ce", slow_ce, exp_ce);

                if (update) begin
                    if (upd_q.size() == 0) check("update_unexpected", update, 0);
                    else begin
                        e = upd_q.pop_front();
                        check("update_cycle", cyc, e.cyc);
                        check("ovf_bank", ovf, e.data);
                    end
                end
                if (upd_q.size() > 0 && upd_q[0].cyc < cyc) begin
                    e = upd_q.pop_front();
                    check("update_missing", update, 1);
                end

                if (rd_ack) begin
                    if (rd_q.size() == 0) check("rd_ack_unexpected", rd_ack, 0);
                    else begin
                        e = rd_q.pop_front();
                        check("rd_ack_cycle", cyc, e.cyc);
                        check("rd_data", rd_data, e.data);
                    end
                end
                if (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
                    e = rd_q.pop_front();
                    check("rd_ack_missing", rd_ack, 1);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_read(input logic [2:0] a, output logic [CW-1:0] d);
        rd_req  = 1'b1;
        rd_addr = a;
        @(negedge clk);
        d      = rd_data;
        rd_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_update(input int budget, output int at_cyc);
        int n;
        n = 0;
        while (!update && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("update_within_budget", update, 1);
        at_cyc = cyc;
    endtask

    initial begin
        int            en_cyc;
        int            up_cyc;
        int            cnt;
        logic [CW-1:0] d;

        step(3);
        check("rst_slow_ce", slow_ce, 0);
        check("rst_update", update, 0);
        check("rst_rd_ack", rd_ack, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        step(1);

        // Case 1: prescale 3, period 4, five pulses on ch0.
        prescale = 8'd3;
        period   = 16'd4;
        enable   = 1'b1;
        en_cyc   = cyc + 1;
        step(1);
        for (int k = 0; k < 10; k++) begin
            scal[0] = (k % 2 == 0);
            step(1);
        end
        scal = '0;
        wait_update(40, up_cyc);
        check("case1_update_delay", up_cyc - en_cyc, 17);
        do_read(3'd0, d);
        check("case1_ch0", d, 5);

        // Case 4: drop enable mid-period; no update and the bank is unchanged.
        scal[0] = 1'b1; step(1);
        scal    = '0;   step(1);
        scal[0] = 1'b1; step(1);
        scal    = '0;
        enable  = 1'b0;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            cnt += int'(update);
        end
        check("case4_no_update", cnt, 0);
        do_read(3'd0, d);
        check("case4_hold_ch0", d, 5);

        // A held request is acknowledged every second cycle, also while idle.
        rd_req  = 1'b1;
        rd_addr = 3'd0;
        cnt     = 0;
        repeat (4) begin
            @(negedge clk);
            cnt += int'(rd_ack);
        end
        rd_req = 1'b0;
        step(1);
        check("held_req_acks", cnt, 2);

        // Case 6: asynchronous reset mid-COUNT.
        prescale = 8'd1;
        period   = 16'd5;
        enable   = 1'b1;
        step(1);
        scal = 8'h0F; step(2);
        scal = '0;    step(2);
        #2 rst_n = 1'b0;
        #1;
        check("areset_slow_ce", slow_ce, 0);
        check("areset_update", update, 0);
        check("areset_rd_ack", rd_ack, 0);
        check("areset_rd_data", rd_data, 0);
        check("areset_ovf", ovf, 0);
        enable = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        do_read(3'd0, d);
        check("post_reset_ch0", d, 0);
        do_read(3'd3, d);
        check("post_reset_ch3", d, 0);

        // Cases 3 and 5: pulse and read exactly in the LATCH cycle.
        prescale = 8'd1;
        period   = 16'd8;
        enable   = 1'b1;
        step(1);
        for (int k = 0; k < 16; k++) begin
            scal[1] = (k < 6) && (k % 2 == 0);
            step(1);
        end
        scal    = 8'h04;
        rd_req  = 1'b1;
        rd_addr = 3'd2;
        @(negedge clk);
        check("case5_latch_read_prelatch", rd_data, 0);
        check("case3_update_after_latch", update, 1);
        scal   = '0;
        rd_req = 1'b0;
        step(1);
        do_read(3'd1, d);
        check("case5_second_read_ch1", d, 3);
        do_read(3'd2, d);
        check("case3_old_bank_ch2", d, 0);
        wait_update(60, up_cyc);
        do_read(3'd2, d);
        check("case3_next_bank_ch2", d, 1);
        enable = 1'b0;
        step(3);

        // Randomized traffic against the reference model.
        for (int r = 0; r < 6; r++) begin
            enable = 1'b0;
            scal   = '0;
            rd_req = 1'b0;
            step(2);
            prescale = 8'($urandom_range(0, 3));
            period   = 16'($urandom_range(0, 5));
            step(1);
            enable = 1'b1;
            for (int k = 0; k < 150; k++) begin
                scal = NCH'($urandom);
                if (rd_req) rd_req = 1'b0;
                else if ($urandom_range(0, 3) == 0) begin
                    rd_req  = 1'b1;
                    rd_addr = 3'($urandom);
                end
                if ($urandom_range(0, 99) == 0) enable = ~enable;
                step(1);
            end
        end
        enable = 1'b0;
        scal   = '0;
        rd_req = 1'b0;
        step(3);

        // Case 2: ch7 saturates over a 0xFFFF-tick period.
        prescale = 8'd0;
        period   = 16'hFFFF;
        step(1);
        enable = 1'b1;
        step(1);
        scal[7] = 1'b1;
        cnt = 0;
        for (int k = 0; k < 70000; k++) begin
            step(1);
            cnt += int'(update);
        end
        scal   = '0;
        enable = 1'b0;
        step(2);
        check("case2_updates", cnt, 1);
        check("case2_ovf", ovf, 8'h80);
        do_read(3'd7, d);
        check("case2_ch7", d, 16'hFFFF);
        for (int ch = 0; ch < 7; ch++) begin
            do_read(3'(ch), d);
            check("case2_other_ch", d, 0);
        end

        step(3);
        check("rd_queue_drained", rd_q.size(), 0);
        check("update_queue_drained", upd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/trigger_scaler_ctrl.md
TRIGGER_SCALER_CTRL -- requirements
Module: trigger_scaler_ctrl

Interface
REQ-001 Parameter: NCH, default 8, number of scaler channels (0-3 TDA, 4-7 reserved).
REQ-002 Parameter: CW, default 16, counter width in bits.
REQ-003 clk_i  in  1  sole clock; all logic is synchronous to its rising edge.
REQ-004 rst_n_i  in  1  asynchronous, active-low reset.
REQ-005 enable_i  in  1  level; high = run gating periods, low = idle.
REQ-006 prescale_i  in  8  number of clk_i cycles per slow tick, minus 1.
REQ-007 period_i  in  16  gate length in slow ticks; a value of 0 is treated as 1.
REQ-008 scal_i  in  NCH  one-cycle scaler pulses, synchronous to clk_i.
REQ-009 slow_ce_o  out  1  one-cycle slow-tick strobe.
REQ-010 update_o  out  1  one-cycle pulse when a new count bank is latched.
REQ-011 rd_req_i  in  1  read request, held high until acknowledged.
REQ-012 rd_addr_i  in  3  channel to read; must be stable while rd_req_i is high.
REQ-013 rd_ack_o  out  1  one-cycle read acknowledge.
REQ-014 rd_data_o  out  CW  latched count of the addressed channel; valid while rd_ack_o is high.
REQ-015 ovf_o  out  NCH  per-channel saturation flags for the latched bank.

Function
REQ-016 Prescaler: a counter runs from 0 to prescale_i, wraps to 0, and pulses slow_ce_o on the wrap cycle; it is held at 0 with slow_ce_o low while in IDLE.
REQ-017 prescale_i = 0 drives slow_ce_o high on every cycle in COUNT.
REQ-018 FSM states are IDLE, COUNT and LATCH.
REQ-019 IDLE -> COUNT when enable_i is high; on entry the tick counter and all live counters are zeroed.
REQ-020 COUNT -> LATCH on the slow_ce_o cycle in which the tick counter equals max(period_i,1)-1; otherwise the tick counter increments on each slow_ce_o.
REQ-021 LATCH lasts exactly one cycle: live counts are copied into the holding bank, live saturation flags are copied into ovf_o, and update_o pulses in the cycle after LATCH.
REQ-022 LATCH -> COUNT if enable_i is high, else LATCH -> IDLE.
REQ-023 COUNT -> IDLE immediately when enable_i goes low; the partial period is discarded and the holding bank is unchanged.
REQ-024 Live counter: in COUNT, scal_i[i] high adds 1; at 2^CW-1 the counter holds and sets live flag i.
REQ-025 Boundary: a pulse present in the LATCH cycle is counted into the new period, so that counter equals 1 after the latch; it is not lost and not counted in the old bank.
REQ-026 Period parameters (period_i, prescale_i) are sampled live; a change takes effect at the next comparison.
REQ-027 Read: rd_req_i high while rd_ack_o is low causes rd_ack_o=1 on the next cycle, with rd_data_o equal to holding[rd_addr_i].
REQ-028 One acknowledge is given per request; a held rd_req_i re-acknowledges every second cycle.
REQ-029 A read coinciding with a latch edge returns the holding value from before that latch.
REQ-030 rd_addr_i >= NCH returns 0.
REQ-031 Reads are serviced in every FSM state.

Reset
REQ-032 rst_n_i low asynchronously forces IDLE and clears all counters, the holding bank, ovf_o, slow_ce_o, update_o, rd_ack_o and rd_data_o to 0.
REQ-033 Reset mid-period discards all counts; there is no update_o pulse on reset release.
REQ-034 The first edge after rst_n_i deasserts may begin the IDLE -> COUNT transition.

Verification
REQ-035 Case 1: prescale_i=3, period_i=4, enable_i high, scal_i[0] pulsed 5 times -> slow_ce_o fires every 4 cycles, update_o fires 17 cycles after enable, and a read of ch0 returns 5.
REQ-036 Case 2: ch7 pulsed every cycle for 70000 cycles with period_i=0xFFFF -> ch7 reads 0xFFFF and ovf_o[7]=1, while the other channels read 0.
REQ-037 Case 3: pulse on scal_i[2] exactly in the LATCH cycle -> the old bank excludes it and the next bank for ch2 reads at least 1.
REQ-038 Case 4: enable_i dropped mid-period -> IDLE, no update_o, and the holding bank still returns the previous values.
REQ-039 Case 5: rd_req_i asserted in the same cycle as LATCH -> the ack returns the pre-latch value; a second read returns the new value.
REQ-040 Case 6: rst_n_i pulsed low asynchronously mid-COUNT -> all outputs are 0 immediately, and a read after reset returns 0.
